// File: rtl/onewire_slot_engine.sv
`default_nettype none
// ============================================================================
// Module   : onewire_slot_engine
// Purpose  : 1-Wire bit-slot engine. Runs 1..DATA_W write or read slots,
//            LSB first, and has its own cycle-accurate slot timer.
// Revision : 1.0 - initial release
// ============================================================================
module onewire_slot_engine #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int DATA_W    = 8,
    parameter int T_SLOT_US = 70,
    parameter int T_LOW0_US = 60,
    parameter int T_LOW1_US = 6,
    parameter int T_SAMP_US = 15
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic                        rd_mode,
    input  logic [$clog2(DATA_W+1)-1:0] nbits,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        dq_in,
    output logic                        dq_out_en,
    output logic                        busy,
    output logic                        done,
    output logic [DATA_W-1:0]           data_out
);

    localparam int c_us_cyc = CLK_FREQ / 1_000_000;
    localparam int c_slot   = T_SLOT_US * c_us_cyc;
    localparam int c_l0     = T_LOW0_US * c_us_cyc;
    localparam int c_l1     = T_LOW1_US * c_us_cyc;
    localparam int c_samp_i = T_SAMP_US * c_us_cyc;
    localparam int c_cnt_w  = $clog2(c_slot);
    localparam int c_nb_w   = $clog2(DATA_W + 1);
    localparam int c_idx_w  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [c_cnt_w-1:0] c_slot_m1 = c_cnt_w'(c_slot - 1);
    localparam logic [c_cnt_w-1:0] c_l0_m1   = c_cnt_w'(c_l0 - 1);
    localparam logic [c_cnt_w-1:0] c_l1_m1   = c_cnt_w'(c_l1 - 1);
    localparam logic [c_cnt_w-1:0] c_samp    = c_cnt_w'(c_samp_i);
    localparam logic [c_nb_w-1:0]  c_max_n   = c_nb_w'(DATA_W);

    if ((CLK_FREQ % 1_000_000) != 0 || c_us_cyc < 4) begin : g_bad_clk
        $error("onewire_slot_engine: CLK_FREQ must be an integer number of MHz, at least 4");
    end
    if (!(T_LOW1_US < T_SAMP_US && T_SAMP_US < T_SLOT_US && T_LOW0_US < T_SLOT_US)) begin : g_bad_timing
        $error("onewire_slot_engine: illegal slot timing parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOW     = 2'd1,
        S_RELEASE = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [c_cnt_w-1:0]  r_cnt, w_cnt_nxt;
    logic [c_idx_w-1:0]  r_idx, w_idx_nxt;
    logic [c_nb_w-1:0]   r_n, w_n_nxt;
    logic                r_rd, w_rd_nxt;
    logic [DATA_W-1:0]   r_data, w_data_nxt;
    logic [DATA_W-1:0]   r_shift, w_shift_nxt;
    logic [DATA_W-1:0]   r_dout, w_dout_nxt;
    logic                r_done, w_done_nxt;
    logic                r_dq_oe;
    logic [1:0]          r_sync;
    logic [c_cnt_w-1:0]  w_llow_m1;
    logic                w_last;

    // Short low for read slots and write-1; long low only for write-0.
    assign w_llow_m1 = (r_rd || r_data[r_idx]) ? c_l1_m1 : c_l0_m1;
    assign w_last    = ((c_nb_w'(r_idx) + 1'b1) == r_n);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_n_nxt     = r_n;
        w_rd_nxt    = r_rd;
        w_data_nxt  = r_data;
        w_shift_nxt = r_shift;
        w_dout_nxt  = r_dout;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_rd_nxt    = rd_mode;
                    w_data_nxt  = data_in;
                    w_n_nxt     = (nbits > c_max_n) ? c_max_n : nbits;
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_shift_nxt = '0;
                    if (nbits == '0) begin
                        w_done_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_LOW;
                    end
                end
            end
            S_LOW: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == w_llow_m1) begin
                    w_state_nxt = S_RELEASE;
                end
            end
            S_RELEASE: begin
                if (r_rd && r_cnt == c_samp) begin
                    w_shift_nxt[r_idx] = r_sync[1];
                end
                if (r_cnt == c_slot_m1) begin
                    w_cnt_nxt = '0;
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                        if (r_rd) begin
                            w_dout_nxt = w_shift_nxt;
                        end
                    end else begin
                        w_idx_nxt   = r_idx + 1'b1;
                        w_state_nxt = S_LOW;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_n     <= '0;
            r_rd    <= 1'b0;
            r_data  <= '0;
            r_shift <= '0;
            r_dout  <= '0;
            r_done  <= 1'b0;
            r_dq_oe <= 1'b0;
            r_sync  <= 2'b00;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_n     <= w_n_nxt;
            r_rd    <= w_rd_nxt;
            r_data  <= w_data_nxt;
            r_shift <= w_shift_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
            // Registered pad enable keeps the open-drain control glitch-free.
            r_dq_oe <= (w_state_nxt == S_LOW);
            r_sync  <= {r_sync[0], dq_in};
        end
    end

    assign dq_out_en = r_dq_oe;
    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign data_out  = r_dout;

endmodule
`default_nettype wire

// File: tb/tb_onewire_slot_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_onewire_slot_engine
// Purpose  : Directed, table-driven self-checking bench for onewire_slot_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_onewire_slot_engine;

    localparam int SLOT = 700;
    localparam int L0   = 600;
    localparam int L1   = 60;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rd_mode = 1'b0;
    logic [3:0] nbits = 4'd0;
    logic [7:0] data_in = 8'h00;
    wire        dq_in;
    logic       dq_out_en, busy, done;
    logic [7:0] data_out;

    logic       slave_bit = 1'b1;
    logic [7:0] slave_val = 8'hFF;
    int         slot_k = 0;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         pstart[$];
    int         plen[$];
    int         busy_cnt;
    logic [7:0] dout_at_done;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Open-drain bus with pull-up: low when master or slave pulls it.
    assign dq_in = dq_out_en ? 1'b0 : slave_bit;

    onewire_slot_engine #(
        .CLK_FREQ (10_000_000),
        .DATA_W   (8),
        .T_SLOT_US(70),
        .T_LOW0_US(60),
        .T_LOW1_US(6),
        .T_SAMP_US(15)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .rd_mode  (rd_mode),
        .nbits    (nbits),
        .data_in  (data_in),
        .dq_in    (dq_in),
        .dq_out_en(dq_out_en),
        .busy     (busy),
        .done     (done),
        .data_out (data_out)
    );

    // Slave: on each master low pulse, present the next bit for 300 cycles.
    initial begin
        forever begin
            @(posedge dq_out_en);
            slave_bit = (slot_k < 8) ? slave_val[slot_k] : 1'b1;
            slot_k = slot_k + 1;
            repeat (300) @(posedge clk);
            slave_bit = 1'b1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic txn(input bit rd, input logic [3:0] nb, input logic [7:0] d,
                       input logic [7:0] sv, input int glitch_at, output int done_c);
        int  t0;
        int  c;
        int  last;
        bit  prev;
        @(posedge clk); #1;
        slave_val = sv; slot_k = 0;
        rd_mode = rd; nbits = nb; data_in = d; start = 1'b1;
        t0 = cyc;
        pstart.delete(); plen.delete();
        busy_cnt = 0; done_c = -1; prev = 1'b0; last = 0;
        @(posedge clk); #1;
        start = 1'b0; rd_mode = ~rd; nbits = 4'd1; data_in = ~d;
        for (int i = 0; i < 7000; i++) begin
            @(negedge clk);
            c = cyc - t0;
            if (c == glitch_at) start = 1'b1;
            else if (c == glitch_at + 1) start = 1'b0;
            if (busy) busy_cnt = busy_cnt + 1;
            if (dq_out_en && !prev) begin pstart.push_back(c); last = c; end
            if (!dq_out_en && prev) plen.push_back(c - last);
            prev = dq_out_en;
            if (done) begin done_c = c; dout_at_done = data_out; break; end
        end
    endtask

    typedef struct {
        bit         rd;
        logic [3:0] nb;
        logic [7:0] d;
        logic [7:0] sv;
        int         slots;
        int         done_lat;
        logic [7:0] short_mask;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int   dc;
        int   c;
        int   t0;
        int   n_done;
        int   n_oe;

        vecs[0] = '{1'b1, 4'd8,  8'h00, 8'h3C, 8, 5601, 8'hFF, 8'h3C};
        vecs[1] = '{1'b0, 4'd8,  8'hA5, 8'hFF, 8, 5601, 8'hA5, 8'h3C};
        vecs[2] = '{1'b1, 4'd3,  8'h00, 8'h03, 3, 2101, 8'hFF, 8'h03};
        vecs[3] = '{1'b1, 4'd12, 8'h00, 8'h96, 8, 5601, 8'hFF, 8'h96};
        vecs[4] = '{1'b0, 4'd0,  8'hFF, 8'hFF, 0, 1,    8'h00, 8'h96};
        vecs[5] = '{1'b0, 4'd3,  8'h02, 8'hFF, 3, 2101, 8'h02, 8'h96};

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_dq_out_en", dq_out_en, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_data_out", data_out, 0);

        for (int v = 0; v < 6; v++) begin
            txn(vecs[v].rd, vecs[v].nb, vecs[v].d, vecs[v].sv, -1, dc);
            chk($sformatf("v%0d_done_cycle", v), dc, vecs[v].done_lat);
            chk($sformatf("v%0d_slot_count", v), pstart.size(), vecs[v].slots);
            for (int k = 0; k < vecs[v].slots && k < pstart.size(); k++) begin
                chk($sformatf("v%0d_pulse%0d_start", v, k), pstart[k], 1 + k * SLOT);
                if (k < plen.size())
                    chk($sformatf("v%0d_pulse%0d_len", v, k), plen[k],
                        vecs[v].short_mask[k] ? L1 : L0);
            end
            chk($sformatf("v%0d_busy_cycles", v), busy_cnt, vecs[v].slots * SLOT);
            chk($sformatf("v%0d_data_out", v), dout_at_done, vecs[v].dout);
        end

        // Start pulse in the middle of a write: must not disturb anything.
        txn(1'b0, 4'd2, 8'h01, 8'hFF, 300, dc);
        chk("glitch_done_cycle", dc, 1401);
        chk("glitch_slot_count", pstart.size(), 2);
        if (pstart.size() == 2 && plen.size() == 2) begin
            chk("glitch_pulse1_start", pstart[1], 701);
            chk("glitch_pulse0_len", plen[0], L1);
            chk("glitch_pulse1_len", plen[1], L0);
        end
        chk("glitch_data_out", dout_at_done, 8'h96);

        // Start held high: next transaction's low pulse begins right after done.
        @(posedge clk); #1;
        rd_mode = 1'b0; nbits = 4'd1; data_in = 8'h01; start = 1'b1;
        t0 = cyc; dc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin dc = cyc - t0; break; end
        end
        chk("held_first_done", dc, 701);
        @(negedge clk);
        chk("held_second_low", dq_out_en, 1);
        chk("held_second_busy", busy, 1);
        start = 1'b0;
        dc = -1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (done) begin dc = cyc - t0; break; end
        end
        chk("held_second_done", dc, 1402);

        // Reset during the low phase of a write-0 slot.
        @(posedge clk); #1;
        rd_mode = 1'b0; nbits = 4'd1; data_in = 8'h00; start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1 start = 1'b0;
        c = 0;
        while (c < 300) begin
            @(negedge clk);
            c = cyc - t0;
            if (c == 299) chk("rst_pre_low", dq_out_en, 1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_dq_out_en", dq_out_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_data_out", data_out, 0);
        n_done = 0; n_oe = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (done) n_done = n_done + 1;
            if (dq_out_en) n_oe = n_oe + 1;
        end
        chk("rst_no_done", n_done, 0);
        chk("rst_no_low", n_oe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
